// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 8,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       row_en,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       busy
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_CAP  = DIV_W'(SCAN_DIV - 2);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = '1;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        REPORT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [1:0]       col_idx, col_idx_n;
    logic [1:0]       row_idx, row_idx_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic [DEB_W-1:0] deb_cnt, deb_cnt_n, deb_inc;
    logic [1:0]       low_row;
    logic             tracked;

    // Lowest set row wins so a multi-key press resolves deterministically.
    always_comb begin
        low_row = 2'd0;
        if (row_in[0])      low_row = 2'd0;
        else if (row_in[1]) low_row = 2'd1;
        else if (row_in[2]) low_row = 2'd2;
        else if (row_in[3]) low_row = 2'd3;
    end

    assign tracked = row_in[row_idx];
    assign deb_inc = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
    assign col_out = 4'b0001 << col_idx;
    assign busy    = (state != SCAN);

    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        row_idx_n = row_idx;
        div_cnt_n = div_cnt;
        deb_cnt_n = deb_cnt;
        row_en    = 1'b0;
        case (state)
            SCAN: begin
                row_en = (div_cnt == DIV_CAP);
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (row_in == 4'b0000) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        row_idx_n = low_row;
                        deb_cnt_n = '0;
                        state_n   = DEBOUNCE;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                row_en = 1'b1;
                if (!tracked) begin
                    state_n   = SCAN;
                    col_idx_n = 2'd0;
                    div_cnt_n = '0;
                    deb_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n = REPORT;
                end else begin
                    deb_cnt_n = deb_inc;
                end
            end
            REPORT: begin
                deb_cnt_n = '0;
                state_n   = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                row_en = 1'b1;
                if (tracked) begin
                    deb_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n   = SCAN;
                    col_idx_n = 2'd0;
                    div_cnt_n = '0;
                    deb_cnt_n = '0;
                end else begin
                    deb_cnt_n = deb_inc;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    // key_valid is registered out of REPORT, landing one cycle after that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            div_cnt   <= div_cnt_n;
            deb_cnt   <= deb_cnt_n;
            key_valid <= (state == REPORT);
            if (state == REPORT) key_code <= {row_idx, col_idx};
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CNT=3)
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       row_en;
    logic [3:0] key_code;
    logic       key_valid;
    logic       busy;

    int checks   = 0;
    int errors   = 0;
    int kv_count = 0;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .row_en    (row_en),
        .key_code  (key_code),
        .key_valid (key_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_valid === 1'b1) kv_count++;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        row_in = 4'b0000;
        tick(2);
        check("rst_col_out", col_out, 4'b0001);
        check("rst_row_en", row_en, 0);
        check("rst_busy", busy, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 4'h0);

        // idle scan: each column held 4 cycles, row_en at div_cnt==2
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("idle_col_out", col_out, 4'b0001 << (i / 4));
            check("idle_row_en", row_en, ((i % 4) == 2) ? 1 : 0);
            check("idle_key_valid", key_valid, 0);
            check("idle_busy", busy, 0);
            tick(1);
        end
        check("idle_wrap", col_out, 4'b0001);

        // clean press on row 2 at column 1
        tick(4);
        check("press_col1", col_out, 4'b0010);
        row_in = 4'b0100;
        tick(3);
        check("press_pre_busy", busy, 0);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check("press_deb_busy", busy, 1);
            check("press_deb_kv", key_valid, 0);
            check("press_col_held", col_out, 4'b0010);
            tick(1);
        end
        check("press_kv", key_valid, 1);
        check("press_code", key_code, 4'b1001);
        check("press_busy", busy, 1);
        tick(1);
        check("press_kv_once", key_valid, 0);
        check("press_code_hold", key_code, 4'b1001);

        // hold 20 cycles after the report, then release
        for (int i = 0; i < 19; i++) begin
            check("hold_kv", key_valid, 0);
            check("hold_busy", busy, 1);
            check("hold_row_en", row_en, 1);
            tick(1);
        end
        row_in = 4'b0000;
        tick(2);
        check("rel_still_busy", busy, 1);
        tick(1);
        check("rel_busy", busy, 0);
        check("rel_col_out", col_out, 4'b0001);
        check("rel_kv_total", kv_count, 1);

        // bounce during debounce on column 0
        row_in = 4'b0100;
        tick(4);
        check("bnc_busy", busy, 1);
        tick(1);
        row_in = 4'b0000;
        tick(1);
        check("bnc_busy_drop", busy, 0);
        check("bnc_col_out", col_out, 4'b0001);
        tick(6);
        check("bnc_kv_total", kv_count, 1);
        check("bnc_code_kept", key_code, 4'b1001);

        // multi-key at column 3: row 1 wins over row 3
        tick(6);
        check("multi_col3", col_out, 4'b1000);
        row_in = 4'b1010;
        tick(4);
        check("multi_busy", busy, 1);
        tick(3);
        check("multi_kv_early", key_valid, 0);
        tick(1);
        check("multi_kv", key_valid, 1);
        check("multi_code", key_code, 4'b0111);
        row_in = 4'b0000;
        tick(3);
        check("multi_rel_busy", busy, 0);
        check("multi_kv_total", kv_count, 2);

        // reset while in DEBOUNCE, key still held
        row_in = 4'b0001;
        tick(5);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick(1);
        check("mrst_col_out", col_out, 4'b0001);
        check("mrst_busy", busy, 0);
        check("mrst_kv", key_valid, 0);
        check("mrst_code", key_code, 4'h0);
        check("mrst_row_en", row_en, 0);
        reset = 1'b0;
        tick(7);
        check("redet_kv_early", key_valid, 0);
        tick(1);
        check("redet_kv", key_valid, 1);
        check("redet_code", key_code, 4'b0000);
        tick(1);
        check("redet_kv_once", key_valid, 0);

        // reset landing on the REPORT cycle must suppress the pulse
        row_in = 4'b0000;
        tick(3);
        check("rep_idle", busy, 0);
        row_in = 4'b0010;
        tick(7);
        reset = 1'b1;
        tick(1);
        check("rrep_kv", key_valid, 0);
        check("rrep_busy", busy, 0);
        reset  = 1'b0;
        row_in = 4'b0000;
        tick(2);
        check("rrep_kv_total", kv_count, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
